regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised register file with integrated scoreboard, for the next-generation 5-stage pipeline.
//  Sits between ID (reads sources, reserves destination at issue) and WB (commits results).
//  Provides WB->ID write-through bypass and per-register in-flight write counters.
//  Counters drive a stall request, so RAW hazards are detected inside the register file.
// PARAMETERS
//  DATA_W        32  register data width
//  NUM_REGS      32  number of architectural registers; reg 0 is hardwired zero
//  ADDR_W         5  register address width, must equal clog2(NUM_REGS)
//  NUM_RD         2  number of read ports
//  MAX_INFLIGHT   3  max outstanding writes tracked per register; CNT_W = clog2(MAX_INFLIGHT+1)
// PORTS
//  clk       in   1               clock, all state updates on rising edge
//  rst       in   1               asynchronous, active-high reset
//  rd_en     in   NUM_RD          per-port read enable
//  rd_addr   in   NUM_RD*ADDR_W   read addresses; port i at [i*ADDR_W +: ADDR_W]
//  rd_data   out  NUM_RD*DATA_W   read data; port i at [i*DATA_W +: DATA_W]
//  rd_busy   out  NUM_RD          port i's source has an uncommitted pending write
//  iss_en    in   1               reserve destination register iss_addr (instruction leaves ID)
//  iss_addr  in   ADDR_W          destination register being reserved
//  wb_en     in   1               write-back commit
//  wb_addr   in   ADDR_W          write-back register
//  wb_data   in   DATA_W          write-back data
//  flush     in   1               clear all pending counters (pipeline squashed/drained)
//  stall     out  1               stall request to ID/IF
//  sb_err    out  1               sticky: write-back to register with zero pending count
// BEHAVIOUR
//  Reset (async, rst=1):
//   - all registers, all pend[] counters and sb_err cleared to 0.
//   - rd_data, rd_busy and stall forced to 0 while rst is high.
//  Reads (combinational, 0-cycle latency):
//   - rd_en[i]=0 or rd_addr=0 -> rd_data=0, rd_busy=0.
//   - wb_en && wb_addr==rd_addr!=0 -> rd_data=wb_data (bypass).
//   - Otherwise rd_data = regs[rd_addr].
//  Write: regs[wb_addr] <= wb_data on clk when wb_en && wb_addr!=0. Writes to reg 0 are ignored.
//  Scoreboard, per register r != 0, pend[r] is CNT_W bits:
//   - inc = iss_en && iss_addr==r && !full
//   - dec = wb_en && wb_addr==r && pend[r]!=0
//   - inc && dec -> pend unchanged; inc alone -> +1; dec alone -> -1.
//   - full = pend[iss_addr]==MAX_INFLIGHT && !(wb_en && wb_addr==iss_addr).
//     When full, the issue is dropped and stall is asserted.
//   - Write-back with pend==0 (r!=0): data is still written, counter stays 0, sb_err <= 1.
//     sb_err clears only on reset.
//   - flush=1: every pend <= 0 on that edge, overriding inc/dec. The data write still occurs.
//   - iss_addr=0 is never reserved; pend[0] is constantly 0.
//  Hazard outputs:
//   - rd_busy[i] = rd_en[i] && rd_addr!=0 && pend[a]!=0 && !(wb_en && wb_addr==a && pend[a]==1).
//     A last pending write committing this cycle is satisfied by the bypass.
//   - stall = |rd_busy || (iss_en && iss_addr!=0 && full).
//   - stall is combinational. ID holds iss_en low itself while stalled. This block does not gate iss_en.
// TESTING
//  1) Reset mid-operation: pend[4]=2, regs[4]=5, assert rst -> rd_data, stall and sb_err all 0.
//     After release, pend[4]=0 and a read of r4 returns 0.
//  2) Bypass: wb_en, wb_addr=7, wb_data=0xDEADBEEF with read port 1 on r7 in the same cycle -> rd_data=0xDEADBEEF.
//     Next cycle with no wb -> still 0xDEADBEEF.
//  3) RAW stall: issue r3; next cycle read r3 -> rd_busy=1, stall=1.
//     Commit wb r3=0x11 in a later cycle -> that cycle rd_busy=0 and rd_data=0x11.
//  4) Saturation: issue r9 three times (MAX_INFLIGHT=3), then a 4th issue -> stall=1 and pend[9] stays 3.
//     4th issue plus wb r9 in the same cycle -> no stall, pend[9]=3.
//  5) Reg 0: issue r0, wb r0=0xFFFF, read r0 -> rd_data=0, rd_busy=0, stall=0, pend[0]=0.
//  6) Error and flush: wb r5 with pend[5]=0 -> regs[5] written, sb_err=1 (sticky).
//     Flush with pend[2]=2 plus simultaneous issue r2 -> pend[2]=0.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Register-file bus: ID read/issue ports plus WB commit port, and the hazard
// outputs the register file returns to ID.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     flush;
    logic                     stall;
    logic                     sb_err;

    modport master (
        output rd_en, rd_addr, iss_en, iss_addr, wb_en, wb_addr, wb_data, flush,
        input  rd_data, rd_busy, stall, sb_err
    );

    modport slave (
        input  rd_en, rd_addr, iss_en, iss_addr, wb_en, wb_addr, wb_data, flush,
        output rd_data, rd_busy, stall, sb_err
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with WB->ID bypass and per-register in-flight write counters
// that raise RAW hazards and a stall request directly from the file.
module regfile_sb #(
    parameter int DATA_W       = 32,
    parameter int NUM_REGS     = 32,
    parameter int ADDR_W       = 5,
    parameter int NUM_RD       = 2,
    parameter int MAX_INFLIGHT = 3
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0][CNT_W-1:0]  pend_q, pend_d;
    logic                            sb_err_q, sb_err_d;

    logic                            wb_hit_iss, full, wb_unreserved;
    logic [NUM_RD-1:0][DATA_W-1:0]   rdata;
    logic [NUM_RD-1:0]               rbusy;

    // A commit to the same register this cycle frees a slot for the issue.
    assign wb_hit_iss    = bus.wb_en && (bus.wb_addr == bus.iss_addr);
    assign full          = (pend_q[bus.iss_addr] == CNT_MAX) && !wb_hit_iss;
    assign wb_unreserved = bus.wb_en && (bus.wb_addr != '0) && (pend_q[bus.wb_addr] == '0);

    always_comb begin
        pend_d = pend_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            logic inc, dec;
            inc = bus.iss_en && (bus.iss_addr == ADDR_W'(r)) && !full;
            dec = bus.wb_en  && (bus.wb_addr  == ADDR_W'(r)) && (pend_q[r] != '0);
            case ({inc, dec})
                2'b10:   pend_d[r] = pend_q[r] + CNT_ONE;
                2'b01:   pend_d[r] = pend_q[r] - CNT_ONE;
                default: pend_d[r] = pend_q[r];
            endcase
        end
        pend_d[0] = '0;
        if (bus.flush) pend_d = '0;
    end

    assign sb_err_d = sb_err_q | wb_unreserved;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q   <= '0;
            pend_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            sb_err_q <= sb_err_d;
            if (bus.wb_en && bus.wb_addr != '0) regs_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              act, byp;
        assign a   = bus.rd_addr[i*ADDR_W +: ADDR_W];
        assign act = !rst && bus.rd_en[i] && (a != '0);
        assign byp = bus.wb_en && (bus.wb_addr == a);
        assign rdata[i] = !act ? '0 : (byp ? bus.wb_data : regs_q[a]);
        // The last outstanding write committing now is covered by the bypass.
        assign rbusy[i] = act && (pend_q[a] != '0) && !(byp && pend_q[a] == CNT_ONE);
    end

    assign bus.rd_data = rdata;
    assign bus.rd_busy = rbusy;
    assign bus.stall   = !rst && ((|rbusy) || (bus.iss_en && bus.iss_addr != '0 && full));
    assign bus.sb_err  = sb_err_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Cycle-table bench for regfile_sb: each row drives one cycle and carries the
// combinational outputs expected before that cycle's clock edge.
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();
    regfile_sb #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .NUM_RD(2), .MAX_INFLIGHT(3))
        dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [1:0]  en;
        logic [4:0]  a0, a1;
        logic        iss;
        logic [4:0]  ia;
        logic        wb;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        fl;
        logic [31:0] d0, d1;
        logic [1:0]  bz;
        logic        st, er;
    } vec_t;

    vec_t tbl[$];
    vec_t sbq[$];
    int   npass = 0;
    int   ntot  = 0;
    int   row   = 0;

    function automatic vec_t V(input logic [1:0] en, input logic [4:0] a0, a1,
                               input logic iss, input logic [4:0] ia,
                               input logic wb, input logic [4:0] wa, input logic [31:0] wd,
                               input logic fl, input logic [31:0] d0, d1,
                               input logic [1:0] bz, input logic st, er);
        vec_t v;
        v.en = en; v.a0 = a0; v.a1 = a1; v.iss = iss; v.ia = ia;
        v.wb = wb; v.wa = wa; v.wd = wd; v.fl = fl;
        v.d0 = d0; v.d1 = d1; v.bz = bz; v.st = st; v.er = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.rd_en    = v.en;
        bus.rd_addr  = {v.a1, v.a0};
        bus.iss_en   = v.iss;
        bus.iss_addr = v.ia;
        bus.wb_en    = v.wb;
        bus.wb_addr  = v.wa;
        bus.wb_data  = v.wd;
        bus.flush    = v.fl;
    endtask

    task automatic idle();
        drive(V(0,0,0, 0,0, 0,0,0, 0, 0,0,0,0,0));
    endtask

    task automatic check_out();
        vec_t e;
        e = sbq.pop_front();
        chk("rd_data0", bus.rd_data[31:0],  e.d0);
        chk("rd_data1", bus.rd_data[63:32], e.d1);
        chk("rd_busy",  32'(bus.rd_busy),   32'(e.bz));
        chk("stall",    32'(bus.stall),     32'(e.st));
        chk("sb_err",   32'(bus.sb_err),    32'(e.er));
        row++;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive(v);
        sbq.push_back(v);
        #2;
        check_out();
    endtask

    initial begin
        // Reset held with live read/issue requests: everything must read back 0.
        drive(V(3,3,7, 1,3, 1,7,32'h1234, 0, 0,0,0,0,0));
        #3;
        chk("rst_rd_data", bus.rd_data[31:0] | bus.rd_data[63:32], 32'h0);
        chk("rst_busy",    32'(bus.rd_busy), 32'h0);
        chk("rst_stall",   32'(bus.stall),   32'h0);
        chk("rst_sb_err",  32'(bus.sb_err),  32'h0);
        idle();
        @(negedge clk);
        rst = 1'b0;

        //            en a0 a1  iss ia  wb wa wd            fl  d0        d1            bz st er
        tbl.push_back(V(0, 0, 0, 1, 7,  0, 0, 0,            0,  0,        0,            0, 0, 0)); // reserve r7
        tbl.push_back(V(2, 0, 7, 0, 0,  1, 7, 32'hDEADBEEF, 0,  0,        32'hDEADBEEF, 0, 0, 0)); // bypass
        tbl.push_back(V(2, 0, 7, 0, 0,  0, 0, 0,            0,  0,        32'hDEADBEEF, 0, 0, 0));
        tbl.push_back(V(0, 0, 0, 1, 3,  0, 0, 0,            0,  0,        0,            0, 0, 0)); // RAW
        tbl.push_back(V(1, 3, 0, 0, 0,  0, 0, 0,            0,  0,        0,            1, 1, 0));
        tbl.push_back(V(1, 3, 0, 0, 0,  1, 3, 32'h11,       0,  32'h11,   0,            0, 0, 0));
        tbl.push_back(V(3, 3, 7, 0, 0,  0, 0, 0,            0,  32'h11,   32'hDEADBEEF, 0, 0, 0));
        tbl.push_back(V(0, 0, 0, 1, 9,  0, 0, 0,            0,  0,        0,            0, 0, 0)); // saturate r9
        tbl.push_back(V(0, 0, 0, 1, 9,  0, 0, 0,            0,  0,        0,            0, 0, 0));
        tbl.push_back(V(0, 0, 0, 1, 9,  0, 0, 0,            0,  0,        0,            0, 0, 0));
        tbl.push_back(V(0, 0, 0, 1, 9,  0, 0, 0,            0,  0,        0,            0, 1, 0)); // full
        tbl.push_back(V(0, 0, 0, 1, 9,  1, 9, 32'h99,       0,  0,        0,            0, 0, 0)); // issue+wb
        tbl.push_back(V(1, 9, 0, 0, 0,  0, 0, 0,            0,  32'h99,   0,            1, 1, 0));
        tbl.push_back(V(0, 0, 0, 0, 0,  1, 9, 32'hA1,       0,  0,        0,            0, 0, 0)); // drain 3->2
        tbl.push_back(V(0, 0, 0, 0, 0,  1, 9, 32'hA2,       0,  0,        0,            0, 0, 0)); // 2->1
        tbl.push_back(V(1, 9, 0, 0, 0,  1, 9, 32'hA3,       0,  32'hA3,   0,            0, 0, 0)); // last
        tbl.push_back(V(1, 9, 0, 0, 0,  0, 0, 0,            0,  32'hA3,   0,            0, 0, 0));
        tbl.push_back(V(3, 0, 0, 1, 0,  1, 0, 32'hFFFF,     0,  0,        0,            0, 0, 0)); // reg 0
        tbl.push_back(V(1, 0, 0, 0, 0,  0, 0, 0,            0,  0,        0,            0, 0, 0));
        tbl.push_back(V(2, 0, 5, 0, 0,  1, 5, 32'h55,       0,  0,        32'h55,       0, 0, 0)); // unreserved wb
        tbl.push_back(V(2, 0, 5, 0, 0,  0, 0, 0,            0,  0,        32'h55,       0, 0, 1));
        tbl.push_back(V(0, 0, 0, 1, 2,  0, 0, 0,            0,  0,        0,            0, 0, 1)); // pend[2]=2
        tbl.push_back(V(0, 0, 0, 1, 2,  0, 0, 0,            0,  0,        0,            0, 0, 1));
        tbl.push_back(V(1, 2, 0, 0, 0,  0, 0, 0,            0,  0,        0,            1, 1, 1));
        tbl.push_back(V(1, 2, 0, 1, 2,  1, 6, 32'h66,       1,  0,        0,            1, 1, 1)); // flush
        tbl.push_back(V(3, 2, 6, 0, 0,  0, 0, 0,            0,  0,        32'h66,       0, 0, 1));
        tbl.push_back(V(0, 7, 9, 0, 0,  0, 0, 0,            0,  0,        0,            0, 0, 1)); // disabled
        foreach (tbl[k]) run_vec(tbl[k]);

        // Reset mid-operation: pend[4]=2, regs[4]=5, then rst with a pending read.
        run_vec(V(0, 0, 0, 1, 4,  0, 0, 0,      0,  0, 0, 0, 0, 1));
        run_vec(V(0, 0, 0, 1, 4,  0, 0, 0,      0,  0, 0, 0, 0, 1));
        run_vec(V(0, 0, 0, 1, 4,  0, 0, 0,      0,  0, 0, 0, 0, 1));
        run_vec(V(0, 0, 0, 0, 0,  1, 4, 32'h5,  0,  0, 0, 0, 0, 1));
        run_vec(V(1, 4, 0, 1, 4,  0, 0, 0,      0,  32'h5, 0, 1, 1, 1));
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_data", bus.rd_data[31:0], 32'h0);
        chk("mid_rst_busy",    32'(bus.rd_busy),  32'h0);
        chk("mid_rst_stall",   32'(bus.stall),    32'h0);
        chk("mid_rst_sb_err",  32'(bus.sb_err),   32'h0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        run_vec(V(1, 4, 0, 0, 0,  0, 0, 0,      0,  0, 0, 0, 0, 0));
        // With pend[4] cleared, this commit is unreserved and must flag sb_err.
        run_vec(V(0, 0, 0, 0, 0,  1, 4, 32'h7,  0,  0, 0, 0, 0, 0));
        run_vec(V(1, 4, 0, 0, 0,  0, 0, 0,      0,  32'h7, 0, 0, 0, 1));

        chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
